// File: rtl/macc_pipe.sv
// macc_pipe: elastic multiply-accumulate, a*b+c / a*b-c / a*b+ACC.
// Product formed at accept; final add and ACC read happen entering the output register.

module macc_pipe #(
  parameter int AW  = 64,
  parameter int BW  = 64,
  parameter int CW  = 128,
  parameter int PW  = 129,
  parameter int LAT = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_in_valid,
  output logic          io_in_ready,
  input  logic [AW-1:0] io_mult1,
  input  logic [BW-1:0] io_mult2,
  input  logic [CW-1:0] io_add,
  input  logic [1:0]    io_mode,
  input  logic          io_signed,
  input  logic          io_acc_clr,
  output logic          io_out_valid,
  input  logic          io_out_ready,
  output logic [PW-1:0] io_res,
  output logic [PW-1:0] io_acc,
  output logic          io_busy
);

  localparam int SN = (LAT > 1) ? LAT - 1 : 1;

  logic          adv;
  logic          hazard;
  logic          accept;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] c_ext;
  logic [PW-1:0] prod_in;
  logic [PW-1:0] addn_in;

  logic          fin_vld;
  logic [PW-1:0] fin_prod;
  logic [PW-1:0] fin_addn;
  logic [1:0]    fin_mode;
  logic          stg_busy;
  logic          stg_accw;

  logic          out_vld_q;
  logic [1:0]    out_mode_q;
  logic [PW-1:0] res_q;
  logic [PW-1:0] res_d;
  logic [PW-1:0] acc_q;

  always_comb begin
    if (io_signed) begin
      a_ext = PW'($signed(io_mult1));
      b_ext = PW'($signed(io_mult2));
      c_ext = PW'($signed(io_add));
    end else begin
      a_ext = PW'(io_mult1);
      b_ext = PW'(io_mult2);
      c_ext = PW'(io_add);
    end
  end

  assign prod_in = a_ext * b_ext;
  assign addn_in = (io_mode == 2'd1)
                 ? (~c_ext + PW'(1))
                 : c_ext;

  assign adv    = !out_vld_q || io_out_ready;
  // Any in-flight mode 2/3 op may still change ACC
  assign hazard = (io_mode == 2'd2)
               && (stg_accw || (out_vld_q && out_mode_q[1]));
  assign io_in_ready = adv && !hazard;
  assign accept      = io_in_valid && io_in_ready;

  generate
    if (LAT > 1) begin : g_pipe
      logic [SN-1:0] v_q;
      logic [PW-1:0] p_q [SN];
      logic [PW-1:0] n_q [SN];
      logic [1:0]    m_q [SN];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          v_q <= '0;
        end else if (adv) begin
          v_q[0] <= accept;
          for (int i = 1; i < SN; i++) begin
            v_q[i] <= v_q[i-1];
          end
        end
      end

      always_ff @(posedge clock) begin
        if (adv) begin
          if (accept) begin
            p_q[0] <= prod_in;
            n_q[0] <= addn_in;
            m_q[0] <= io_mode;
          end
          for (int i = 1; i < SN; i++) begin
            if (v_q[i-1]) begin
              p_q[i] <= p_q[i-1];
              n_q[i] <= n_q[i-1];
              m_q[i] <= m_q[i-1];
            end
          end
        end
      end

      always_comb begin
        stg_busy = |v_q;
        stg_accw = 1'b0;
        for (int i = 0; i < SN; i++) begin
          stg_accw = stg_accw | (v_q[i] & m_q[i][1]);
        end
      end

      assign fin_vld  = v_q[SN-1];
      assign fin_prod = p_q[SN-1];
      assign fin_addn = n_q[SN-1];
      assign fin_mode = m_q[SN-1];
    end else begin : g_direct
      assign stg_busy = 1'b0;
      assign stg_accw = 1'b0;
      assign fin_vld  = accept;
      assign fin_prod = prod_in;
      assign fin_addn = addn_in;
      assign fin_mode = io_mode;
    end
  endgenerate

  assign res_d = fin_prod
               + ((fin_mode == 2'd2) ? acc_q : fin_addn);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      out_mode_q <= 2'd0;
      res_q      <= '0;
    end else if (adv) begin
      out_vld_q <= fin_vld;
      if (fin_vld) begin
        res_q      <= res_d;
        out_mode_q <= fin_mode;
      end
    end
  end

  // Clear has priority over a same-cycle write-back
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (io_acc_clr) begin
      acc_q <= '0;
    end else if (out_vld_q && io_out_ready && out_mode_q[1]) begin
      acc_q <= res_q;
    end
  end

  assign io_out_valid = out_vld_q;
  assign io_res       = res_q;
  assign io_acc       = acc_q;
  assign io_busy      = stg_busy || out_vld_q;

endmodule

// File: tb/tb_macc_pipe.sv
// tb_macc_pipe: scoreboard bench for macc_pipe.
// Default instance (LAT=3) plus a narrow LAT=1 instance.

module tb_macc_pipe;

  typedef struct {
    logic [128:0] res;
    int           acc_cyc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   pass_n = 0;
  int   tot_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic         v0, r0, ov0, or0, s0, clr0, bz0;
  logic [63:0]  a0, bb0;
  logic [127:0] c0;
  logic [1:0]   m0;
  logic [128:0] res0, acc0;

  logic         v1, r1, ov1, or1, s1, clr1, bz1;
  logic [7:0]   a1, bb1;
  logic [15:0]  c1;
  logic [1:0]   m1;
  logic [16:0]  res1, acc1;

  exp_t q0[$];
  exp_t q1[$];

  macc_pipe u0 (
    .clock(clk), .reset(rst),
    .io_in_valid(v0), .io_in_ready(r0),
    .io_mult1(a0), .io_mult2(bb0), .io_add(c0),
    .io_mode(m0), .io_signed(s0), .io_acc_clr(clr0),
    .io_out_valid(ov0), .io_out_ready(or0),
    .io_res(res0), .io_acc(acc0), .io_busy(bz0)
  );

  macc_pipe #(
    .AW(8), .BW(8), .CW(16), .PW(17), .LAT(1)
  ) u1 (
    .clock(clk), .reset(rst),
    .io_in_valid(v1), .io_in_ready(r1),
    .io_mult1(a1), .io_mult2(bb1), .io_add(c1),
    .io_mode(m1), .io_signed(s1), .io_acc_clr(clr1),
    .io_out_valid(ov1), .io_out_ready(or1),
    .io_res(res1), .io_acc(acc1), .io_busy(bz1)
  );

  task automatic chk(string nm, logic [128:0] act,
                     logic [128:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  int first0 = -1;
  int first1 = -1;

  always @(negedge clk) begin
    exp_t h;
    if (rst) begin
      q0.delete();
      first0 = -1;
    end else if (ov0) begin
      if (q0.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_out0: got %h want none", res0);
      end else begin
        if (first0 < 0) first0 = cyc;
        if (!or0) begin
          chk("stall_hold0", res0, q0[0].res);
        end else begin
          h = q0.pop_front();
          chk("res0", res0, h.res);
          if (h.lat > 0)
            chk("lat0", 129'(first0 - h.acc_cyc), 129'(h.lat));
          first0 = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t h;
    if (rst) begin
      q1.delete();
      first1 = -1;
    end else if (ov1) begin
      if (q1.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_out1: got %h want none", res1);
      end else begin
        if (first1 < 0) first1 = cyc;
        if (!or1) begin
          chk("stall_hold1", 129'(res1), q1[0].res);
        end else begin
          h = q1.pop_front();
          chk("res1", 129'(res1), h.res);
          if (h.lat > 0)
            chk("lat1", 129'(first1 - h.acc_cyc), 129'(h.lat));
          first1 = -1;
        end
      end
    end
  end

  task automatic issue0(logic [1:0] m, logic s,
                        logic [63:0] a, logic [63:0] b,
                        logic [127:0] c, logic [128:0] e,
                        int lat, output int waits);
    exp_t t;
    waits = 0;
    v0 = 1'b1; m0 = m; s0 = s;
    a0 = a; bb0 = b; c0 = c;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (r0) begin
        t.res = e; t.acc_cyc = cyc; t.lat = lat;
        q0.push_back(t);
        @(posedge clk);
        #1 v0 = 1'b0;
        return;
      end
      waits++;
    end
    tot_n++;
    $display("FAIL issue0_timeout: waited %0d want accept", waits);
    v0 = 1'b0;
  endtask

  task automatic issue1(logic [1:0] m, logic s,
                        logic [7:0] a, logic [7:0] b,
                        logic [15:0] c, logic [16:0] e,
                        int lat, output int waits);
    exp_t t;
    waits = 0;
    v1 = 1'b1; m1 = m; s1 = s;
    a1 = a; bb1 = b; c1 = c;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (r1) begin
        t.res = 129'(e); t.acc_cyc = cyc; t.lat = lat;
        q1.push_back(t);
        @(posedge clk);
        #1 v1 = 1'b0;
        return;
      end
      waits++;
    end
    tot_n++;
    $display("FAIL issue1_timeout: waited %0d want accept", waits);
    v1 = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (q0.size() == 0 && q1.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
    end
    tot_n++;
    $display("FAIL drain_timeout: left %0d/%0d want 0",
             q0.size(), q1.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    int w;
    int stale;
    logic [128:0] neg22;
    rst = 1'b1;
    v0 = 0; m0 = 0; s0 = 0; clr0 = 0; or0 = 1;
    a0 = 0; bb0 = 0; c0 = 0;
    v1 = 0; m1 = 0; s1 = 0; clr1 = 0; or1 = 1;
    a1 = 0; bb1 = 0; c1 = 0;
    #2;
    chk("rst_ov0", 129'(ov0), 129'd0);
    chk("rst_busy0", 129'(bz0), 129'd0);
    chk("rst_res0", res0, 129'd0);
    chk("rst_acc0", acc0, 129'd0);
    chk("rst_ov1", 129'(ov1), 129'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rdy0_after_rst", 129'(r0), 129'd1);
    chk("rdy1_after_rst", 129'(r1), 129'd1);

    // unsigned all-ones mode 0
    issue0(2'd0, 1'b0, '1, '1, '1,
           129'h1_FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0000,
           3, w);
    neg22 = '0;
    neg22 = neg22 - 129'd22;
    issue0(2'd1, 1'b1, -64'd3, 64'd5, 128'd7, neg22, 3, w);
    issue0(2'd0, 1'b1, -64'd2, -64'd3, '1, 129'd5, 3, w);
    drain();

    // accumulate chain with hazard spacing
    clr0 = 1'b1;
    @(posedge clk);
    #1 clr0 = 1'b0;
    issue0(2'd3, 1'b0, 64'd2, 64'd3, 128'd1, 129'd7, 3, w);
    issue0(2'd2, 1'b0, 64'd4, 64'd4, 128'd0, 129'd23, 3, w);
    chk("hz_wait_m3", 129'(w), 129'd3);
    issue0(2'd2, 1'b0, 64'd1, 64'd1, 128'd0, 129'd24, 3, w);
    chk("hz_wait_m2", 129'(w), 129'd3);
    issue0(2'd0, 1'b0, 64'd1, 64'd1, 128'd1, 129'd2, 3, w);
    chk("no_hz_m0", 129'(w), 129'd0);
    drain();
    chk("acc_final", acc0, 129'd24);

    // backpressure: ready low for five cycles
    fork
      begin
        int wi;
        for (int i = 0; i < 5; i++)
          issue0(2'd0, 1'b0, 64'(i + 1), 64'd10, 128'(i),
                 129'(10 * (i + 1) + i), 0, wi);
      end
      begin
        repeat (3) @(posedge clk);
        #1 or0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_inrdy", 129'(r0), 129'd0);
        end
        @(posedge clk);
        #1 or0 = 1'b1;
      end
    join
    drain();

    // async reset with ops in flight
    issue0(2'd0, 1'b0, 64'd3, 64'd3, 128'd0, 129'd9, 0, w);
    issue0(2'd0, 1'b0, 64'd4, 64'd4, 128'd0, 129'd16, 0, w);
    issue0(2'd0, 1'b0, 64'd5, 64'd5, 128'd0, 129'd25, 0, w);
    #1;
    chk("busy_pre_rst", 129'(bz0), 129'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_ov", 129'(ov0), 129'd0);
    chk("rst_mid_busy", 129'(bz0), 129'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ov0) stale++;
    end
    chk("no_stale", 129'(stale), 129'd0);
    chk("acc_after_rst", acc0, 129'd0);
    chk("rdy_after_mid_rst", 129'(r0), 129'd1);

    // LAT=1 narrow instance
    @(posedge clk);
    #1;
    issue1(2'd0, 1'b0, 8'd255, 8'd255, 16'hFFFF,
           17'h1FE00, 1, w);
    drain();
    issue1(2'd3, 1'b0, 8'd2, 8'd3, 16'd1, 17'd7, 1, w);
    drain();
    chk("acc1_load", 129'(acc1), 129'd7);
    issue1(2'd3, 1'b0, 8'd1, 8'd1, 16'd4, 17'd5, 1, w);
    clr1 = 1'b1;
    @(posedge clk);
    #1 clr1 = 1'b0;
    chk("clr_wins", 129'(acc1), 129'd0);
    drain();

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
